memory_access_stage: RTL
========================

// Module: memory_access_stage
// PURPOSE
//  DLX MEM stage: receiver of the execute-stage outputs. Performs data-memory loads/stores over a req/ack
//  handshake, stalls the pipeline while an access is outstanding, resolves branch/jump redirects, and
//  registers results into the MEM/WB boundary for write-back and forwarding.
// PARAMETERS
//  DATA_WIDTH        32  data/address width
//  PC_WIDTH          32  program counter width
//  W_REG_ADDR_WIDTH  5   destination register address width
//  TIMEOUT_CYCLES    16  max ACCESS cycles without ack (used only with MEM_ACCESS_TIMEOUT_EN)
// PORTS
//  clk                     in   1   clock, rising edge
//  rst                     in   1   asynchronous reset, active-high
//  valid_in                in   1   execute stage presents an instruction
//  alu_data_in             in   DW  ALU result / memory address
//  alu_b_data_in           in   DW  store data
//  mem_data_wr_en_in       in   1   store
//  write_back_mux_sel_in   in   1   1 = load (write-back selects memory data)
//  w_reg_wr_en_in          in   1   register write enable
//  w_reg_addr_in           in   RW  destination register
//  branch_inst_in          in   1   conditional branch
//  alu_zero_in             in   1   ALU zero flag
//  jmp_inst_in             in   1   unconditional jump
//  new_pc_in               in   PW  branch/jump target
//  stall_out               out  1   hold upstream; = (state==ACCESS)
//  pc_src_out              out  1   1-cycle redirect pulse
//  new_pc_out              out  PW  redirect target, valid with pc_src_out
//  dmem_req_out            out  1   memory request
//  dmem_we_out             out  1   1 = write
//  dmem_addr_out           out  DW  memory address
//  dmem_wdata_out          out  DW  write data
//  dmem_rdata_in           in   DW  read data, valid with dmem_ack_in
//  dmem_ack_in             in   1   access complete
//  dmem_err_out            out  1   sticky timeout flag
//  wb_valid_out            out  1   MEM/WB entry valid (1-cycle pulse per instruction)
//  mem_data_out            out  DW  loaded data
//  alu_data_out            out  DW  registered ALU result (also forwarding source)
//  write_back_mux_sel_out  out  1   registered mux select
//  w_reg_wr_en_out         out  1   registered write enable
//  w_reg_addr_out          out  RW  registered destination
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; dmem_req_out drops immediately. An in-flight access is abandoned.
//  - FSM IDLE/ACCESS. Acceptance happens at a rising edge with state==IDLE && valid_in. Inputs are
//    ignored in ACCESS; upstream holds its next instruction while stall_out=1.
//  - Non-memory instruction: latency 1. Next cycle wb_valid_out=1 with registered fields; stays IDLE.
//  - Load/store accepted: ->ACCESS. Next cycle dmem_req_out=1 with addr, we and wdata latched stable until
//    ack. Edge with ack=1: req=0; load captures rdata into mem_data_out; wb_valid_out pulses next cycle;
//    ->IDLE. Minimum load/store latency: 2 cycles (ack in first req cycle).
//  - Store and load both set: store wins. No memory read. w_reg_wr_en_out=0.
//  - dmem_ack_in in IDLE: ignored.
//  - pc_src_out = accepted && (jmp_inst_in || (branch_inst_in && alu_zero_in)). Registered at acceptance,
//    1-cycle pulse with new_pc_out, independent of memory state.
//  - Outputs not pulsed hold their last value; wb_valid_out=0 otherwise.
// CONFIGURATION
//  MEM_ACCESS_TIMEOUT_EN defined:
//    - A counter runs while in ACCESS.
//    - After TIMEOUT_CYCLES req cycles with no ack: req=0; ->IDLE; wb_valid_out pulses with
//      w_reg_wr_en_out=0; dmem_err_out=1 (sticky until rst).
//  Undefined:
//    - Waits for ack indefinitely; dmem_err_out tied 0; no counter logic.
// TESTING
//  - ALU op (valid, alu=0x10, wr_en=1, addr=3) -> next cycle wb_valid=1, alu_data_out=0x10,
//    w_reg_addr_out=3, stall=0.
//  - Load addr 0x40, ack after 3 req cycles with rdata=0xDEADBEEF -> stall=1 for 4 cycles; addr stable;
//    mem_data_out=0xDEADBEEF; single wb_valid pulse.
//  - Store addr 0x44, data 0x55, ack same cycle as first req -> dmem_we=1, wdata=0x55; w_reg_wr_en_out=0;
//    total 2 cycles.
//  - Branch with zero=1, target 0x100 -> pc_src_out 1-cycle pulse, new_pc_out=0x100. Zero=0 -> no pulse.
//    Jump -> pulse.
//  - rst asserted mid-ACCESS -> req, stall and wb_valid all 0 immediately; later ack ignored.
//  - MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=4, load with no ack -> req drops after 4 cycles; dmem_err_out=1
//    sticky; wb_valid pulses with w_reg_wr_en_out=0.

Source files
------------

// File: rtl/memory_access_stage_if.sv
// Data-memory request/acknowledge bus between the DLX MEM stage (master) and data memory (slave).
interface memory_access_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  dmem_req_out;
  logic                  dmem_we_out;
  logic [DATA_WIDTH-1:0] dmem_addr_out;
  logic [DATA_WIDTH-1:0] dmem_wdata_out;
  logic [DATA_WIDTH-1:0] dmem_rdata_in;
  logic                  dmem_ack_in;

  modport master (
    output dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out,
    input  dmem_rdata_in, dmem_ack_in
  );

  modport slave (
    input  dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out,
    output dmem_rdata_in, dmem_ack_in
  );
endinterface

// File: rtl/memory_access_stage.sv
// DLX MEM stage: data-memory access FSM, branch/jump redirect and MEM/WB boundary registers.
// Optional access timeout with sticky error flag: define MEM_ACCESS_TIMEOUT_EN.
module memory_access_stage #(
  parameter int DATA_WIDTH       = 32,
  parameter int PC_WIDTH         = 32,
  parameter int W_REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  input  logic [DATA_WIDTH-1:0]       alu_data_in,
  input  logic [DATA_WIDTH-1:0]       alu_b_data_in,
  input  logic                        mem_data_wr_en_in,
  input  logic                        write_back_mux_sel_in,
  input  logic                        w_reg_wr_en_in,
  input  logic [W_REG_ADDR_WIDTH-1:0] w_reg_addr_in,
  input  logic                        branch_inst_in,
  input  logic                        alu_zero_in,
  input  logic                        jmp_inst_in,
  input  logic [PC_WIDTH-1:0]         new_pc_in,
  output logic                        stall_out,
  output logic                        pc_src_out,
  output logic [PC_WIDTH-1:0]         new_pc_out,
  memory_access_stage_if.master       dmem,
  output logic                        dmem_err_out,
  output logic                        wb_valid_out,
  output logic [DATA_WIDTH-1:0]       mem_data_out,
  output logic [DATA_WIDTH-1:0]       alu_data_out,
  output logic                        write_back_mux_sel_out,
  output logic                        w_reg_wr_en_out,
  output logic [W_REG_ADDR_WIDTH-1:0] w_reg_addr_out
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state, next_state;
  logic   accept, mem_op, finish, timeout;

  // Write-back fields of the outstanding load/store, released when the access ends.
  logic                        sel_p0;
  logic                        wr_en_p0;
  logic [W_REG_ADDR_WIDTH-1:0] waddr_p0;

  assign accept    = (state == IDLE) && valid_in;
  assign mem_op    = mem_data_wr_en_in | write_back_mux_sel_in;
  assign stall_out = (state == ACCESS);

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= (state == ACCESS) ? cnt + 1'b1 : '0;
      if (timeout) err <= 1'b1;
    end
  end

  // An ack arriving in the last allowed cycle still completes normally.
  assign timeout      = (state == ACCESS) && !dmem.dmem_ack_in &&
                        (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign dmem_err_out = err;
`else
  assign timeout      = 1'b0;
  assign dmem_err_out = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (accept && mem_op) next_state = ACCESS;
      end
      ACCESS: begin
        if (dmem.dmem_ack_in || timeout) begin
          finish     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sel_p0   <= write_back_mux_sel_in & ~mem_data_wr_en_in;
      wr_en_p0 <= w_reg_wr_en_in & ~mem_data_wr_en_in;
      waddr_p0 <= w_reg_addr_in;
    end
  end

  // Stage boundary: EX outputs -> memory bus and MEM/WB registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_src_out             <= 1'b0;
      new_pc_out             <= '0;
      dmem.dmem_req_out      <= 1'b0;
      dmem.dmem_we_out       <= 1'b0;
      dmem.dmem_addr_out     <= '0;
      dmem.dmem_wdata_out    <= '0;
      wb_valid_out           <= 1'b0;
      mem_data_out           <= '0;
      alu_data_out           <= '0;
      write_back_mux_sel_out <= 1'b0;
      w_reg_wr_en_out        <= 1'b0;
      w_reg_addr_out         <= '0;
    end else begin
      pc_src_out   <= 1'b0;
      wb_valid_out <= 1'b0;
      if (accept) begin
        pc_src_out <= jmp_inst_in | (branch_inst_in & alu_zero_in);
        new_pc_out <= new_pc_in;
        if (mem_op) begin
          dmem.dmem_req_out   <= 1'b1;
          dmem.dmem_we_out    <= mem_data_wr_en_in;
          dmem.dmem_addr_out  <= alu_data_in;
          dmem.dmem_wdata_out <= alu_b_data_in;
        end else begin
          wb_valid_out           <= 1'b1;
          alu_data_out           <= alu_data_in;
          write_back_mux_sel_out <= 1'b0;
          w_reg_wr_en_out        <= w_reg_wr_en_in;
          w_reg_addr_out         <= w_reg_addr_in;
        end
      end
      if (finish) begin
        dmem.dmem_req_out      <= 1'b0;
        wb_valid_out           <= 1'b1;
        alu_data_out           <= dmem.dmem_addr_out;
        write_back_mux_sel_out <= sel_p0;
        w_reg_wr_en_out        <= wr_en_p0 & ~timeout;
        w_reg_addr_out         <= waddr_p0;
        if (dmem.dmem_ack_in && !dmem.dmem_we_out) mem_data_out <= dmem.dmem_rdata_in;
      end
    end
  end

endmodule
